// File: rtl/lcd_16x2_resp.sv
// HD44780-style 16x2 LCD responder (DDRAM, address counter, display state, BF timing); CGRAM storage with LCD_16X2_RESP_CGRAM_EN.
// Latency: E is 2-flop synchronized; writes act one cycle after the synchronized E fall, reads register on the synchronized rise.
// Backpressure: busy (BF) is held for the instruction delay; writes arriving while busy are discarded with a cmd_drop pulse.
module lcd_16x2_resp #(
    parameter int CLR_DELAY  = 76_500,
    parameter int CMD_DELAY  = 1_950,
    parameter int DATA_DELAY = 2_150
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RS,
    input  logic       RW,
    input  logic       E,
    input  logic [7:0] DATA_IN,
    output logic [7:0] DATA_OUT,
    output logic       DATA_OE,
    output logic       busy,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic [5:0] shift_ofs,
    input  logic [6:0] mon_addr,
    output logic [7:0] mon_char,
    output logic       cmd_drop
);

    localparam int MAX_D = (CLR_DELAY > CMD_DELAY)
                         ? ((CLR_DELAY > DATA_DELAY) ? CLR_DELAY : DATA_DELAY)
                         : ((CMD_DELAY > DATA_DELAY) ? CMD_DELAY : DATA_DELAY);
    localparam int CW = $clog2(MAX_D + 1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_WAIT} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [6:0]     clr_idx;
    logic [6:0]     ac;
    logic           cg_sel;
    logic           inc_mode;
    logic           shift_en;
    logic           rd_pend;
    logic           e_s1, e_s2, e_d;
    logic           e_rise, e_fall, wr_acc;
    logic [7:0]     rd_dat;
    logic           dd_we;
    logic [6:0]     dd_widx;
    logic [7:0]     dd_wdat;

    logic [7:0] ddram [0:79];
`ifdef LCD_16X2_RESP_CGRAM_EN
    logic [7:0] cgram [0:63];
`endif

    function automatic logic dd_valid(input logic [6:0] a);
        return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    endfunction

    // Line 2 (0x40..0x67) packs directly after line 1 in the 80-entry array.
    function automatic logic [6:0] dd_index(input logic [6:0] a);
        return a[6] ? (a - 7'd24) : a;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc, input logic cg);
        logic [6:0] r;
        if (cg)
            r = {1'b0, (inc ? (a[5:0] + 6'd1) : (a[5:0] - 6'd1))};
        else if (!dd_valid(a))
            r = a[6] ? 7'h00 : 7'h40;
        else if (inc)
            r = (a == 7'h27) ? 7'h40 : ((a == 7'h67) ? 7'h00 : (a + 7'd1));
        else
            r = (a == 7'h00) ? 7'h67 : ((a == 7'h40) ? 7'h27 : (a - 7'd1));
        return r;
    endfunction

    function automatic logic [5:0] ofs_step(input logic [5:0] o, input logic right);
        if (right)
            return (o == 6'd39) ? 6'd0 : (o + 6'd1);
        else
            return (o == 6'd0) ? 6'd39 : (o - 6'd1);
    endfunction

    assign busy     = (state != S_IDLE);
    assign DATA_OE  = RW & e_s2;
    assign e_rise   = e_s2 & ~e_d;
    assign e_fall   = ~e_s2 & e_d;
    assign wr_acc   = e_fall & ~RW & ~busy;
    assign mon_char = dd_valid(mon_addr) ? ddram[dd_index(mon_addr)] : 8'h00;

    always_comb begin
        rd_dat = 8'h00;
        if (cg_sel) begin
`ifdef LCD_16X2_RESP_CGRAM_EN
            rd_dat = cgram[ac[5:0]];
`endif
        end else if (dd_valid(ac)) begin
            rd_dat = ddram[dd_index(ac)];
        end
    end

    always_comb begin
        dd_we   = 1'b0;
        dd_widx = clr_idx;
        dd_wdat = 8'h20;
        if (state == S_CLEAR) begin
            dd_we = 1'b1;
        end else if (wr_acc && RS && !cg_sel && dd_valid(ac)) begin
            dd_we   = 1'b1;
            dd_widx = dd_index(ac);
            dd_wdat = DATA_IN;
        end
    end

    always_ff @(posedge clk) begin
        if (dd_we)
            ddram[dd_widx] <= dd_wdat;
    end

`ifdef LCD_16X2_RESP_CGRAM_EN
    always_ff @(posedge clk) begin
        if (wr_acc && RS && cg_sel)
            cgram[ac[5:0]] <= DATA_IN;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_s1      <= 1'b0;
            e_s2      <= 1'b0;
            e_d       <= 1'b0;
            state     <= S_CLEAR;
            cnt       <= CW'(CLR_DELAY - 1);
            clr_idx   <= 7'd0;
            ac        <= 7'd0;
            cg_sel    <= 1'b0;
            inc_mode  <= 1'b1;
            shift_en  <= 1'b0;
            disp_on   <= 1'b0;
            cursor_on <= 1'b0;
            blink_on  <= 1'b0;
            shift_ofs <= 6'd0;
            DATA_OUT  <= 8'h00;
            cmd_drop  <= 1'b0;
            rd_pend   <= 1'b0;
        end else begin
            e_s1     <= E;
            e_s2     <= e_s1;
            e_d      <= e_s2;
            cmd_drop <= 1'b0;

            // cnt runs through CLEAR and WAIT so the total busy time equals the loaded delay.
            case (state)
                S_CLEAR: begin
                    if (cnt != '0)
                        cnt <= cnt - CW'(1);
                    clr_idx <= clr_idx + 7'd1;
                    if (clr_idx == 7'd79)
                        state <= (cnt == '0) ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == '0)
                        state <= S_IDLE;
                    else
                        cnt <= cnt - CW'(1);
                end
                default: ;
            endcase

            if (e_rise && RW) begin
                if (!RS) begin
                    DATA_OUT <= {busy, ac};
                end else if (!busy) begin
                    DATA_OUT <= rd_dat;
                    rd_pend  <= 1'b1;
                end else begin
                    DATA_OUT <= 8'h00;
                end
            end

            if (e_fall) begin
                rd_pend <= 1'b0;
                if (RW) begin
                    if (RS && rd_pend && !busy) begin
                        ac    <= ac_step(ac, inc_mode, cg_sel);
                        state <= S_WAIT;
                        cnt   <= CW'(DATA_DELAY - 1);
                    end
                end else if (busy) begin
                    cmd_drop <= 1'b1;
                end else if (RS) begin
                    ac <= ac_step(ac, inc_mode, cg_sel);
                    if (shift_en)
                        shift_ofs <= ofs_step(shift_ofs, inc_mode);
                    state <= S_WAIT;
                    cnt   <= CW'(DATA_DELAY - 1);
                end else begin
                    state <= S_WAIT;
                    cnt   <= CW'(CMD_DELAY - 1);
                    casez (DATA_IN)
                        8'b1???????: begin
                            ac     <= DATA_IN[6:0];
                            cg_sel <= 1'b0;
                        end
                        8'b01??????: begin
                            ac     <= {1'b0, DATA_IN[5:0]};
                            cg_sel <= 1'b1;
                        end
                        8'b001?????: ;
                        8'b0001????: begin
                            if (DATA_IN[3])
                                shift_ofs <= ofs_step(shift_ofs, DATA_IN[2]);
                            else
                                ac <= ac_step(ac, DATA_IN[2], cg_sel);
                        end
                        8'b00001???: begin
                            disp_on   <= DATA_IN[2];
                            cursor_on <= DATA_IN[1];
                            blink_on  <= DATA_IN[0];
                        end
                        8'b000001??: begin
                            inc_mode <= DATA_IN[1];
                            shift_en <= DATA_IN[0];
                        end
                        8'b0000001?: begin
                            ac        <= 7'd0;
                            cg_sel    <= 1'b0;
                            shift_ofs <= 6'd0;
                            cnt       <= CW'(CLR_DELAY - 1);
                        end
                        8'b00000001: begin
                            ac        <= 7'd0;
                            cg_sel    <= 1'b0;
                            inc_mode  <= 1'b1;
                            shift_ofs <= 6'd0;
                            clr_idx   <= 7'd0;
                            state     <= S_CLEAR;
                            cnt       <= CW'(CLR_DELAY - 1);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_16x2_resp.sv
// Directed bench for lcd_16x2_resp with scaled busy delays; bus reads and cmd_drop pulses
// are checked by a monitor against expectations queued by the stimulus.
module tb_lcd_16x2_resp;

    localparam int CLR = 300;
    localparam int CMD = 40;
    localparam int DAT = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RS = 1'b0, RW = 1'b0, E = 1'b0;
    logic [7:0] DATA_IN = 8'h00;
    logic [7:0] DATA_OUT;
    logic       DATA_OE, busy, disp_on, cursor_on, blink_on, cmd_drop;
    logic [5:0] shift_ofs;
    logic [6:0] mon_addr = 7'h00;
    logic [7:0] mon_char;

    int checks = 0;
    int failures = 0;

    logic [7:0] rd_q[$];
    string      rd_name_q[$];
    logic       drop_q[$];

    lcd_16x2_resp #(.CLR_DELAY(CLR), .CMD_DELAY(CMD), .DATA_DELAY(DAT)) dut (
        .clk(clk), .rst_n(rst_n), .RS(RS), .RW(RW), .E(E),
        .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .busy(busy),
        .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .shift_ofs(shift_ofs), .mon_addr(mon_addr), .mon_char(mon_char),
        .cmd_drop(cmd_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic rs, input logic [7:0] d);
        @(negedge clk);
        RS = rs; RW = 1'b0; DATA_IN = d; E = 1'b1;
        repeat (4) @(negedge clk);
        E = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic bus_read(input string name, input logic rs, input logic [7:0] exp);
        rd_q.push_back(exp);
        rd_name_q.push_back(name);
        @(negedge clk);
        RS = rs; RW = 1'b1; E = 1'b1;
        repeat (4) @(negedge clk);
        E = 1'b0;
        repeat (4) @(negedge clk);
        RW = 1'b0;
    endtask

    task automatic status(input string name, input logic [7:0] exp);
        bus_read(name, 1'b0, exp);
    endtask

    // k = negedges until busy is seen low; bounded so a stuck BF ends as a failure.
    task automatic wait_idle(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < 4 * CLR);
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    task automatic cmd(input logic [7:0] d);
        int k;
        bus_write(1'b0, d);
        wait_idle(k);
    endtask

    task automatic dwrite(input logic [7:0] d);
        int k;
        bus_write(1'b1, d);
        wait_idle(k);
    endtask

    task automatic peek(input logic [6:0] a, output logic [7:0] d);
        mon_addr = a;
        #1;
        d = mon_char;
    endtask

    task automatic mon_chk(input string name, input logic [6:0] a, input logic [7:0] exp);
        logic [7:0] d;
        peek(a, d);
        check(name, d, exp);
    endtask

    // Monitor: a completed read is marked by DATA_OE dropping; DATA_OUT holds its value then.
    initial begin
        logic oe_q;
        logic [7:0] e;
        string n;
        oe_q = 1'b0;
        forever begin
            @(negedge clk);
            if (oe_q && !DATA_OE) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_read actual=0x%0h required=none", DATA_OUT);
                end else begin
                    e = rd_q.pop_front();
                    n = rd_name_q.pop_front();
                    check(n, DATA_OUT, e);
                end
            end
            if (cmd_drop) begin
                if (drop_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_cmd_drop actual=1 required=0");
                end else begin
                    check("cmd_drop", cmd_drop, drop_q.pop_front());
                end
            end
            oe_q = DATA_OE;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        logic [7:0] v;

        repeat (3) @(negedge clk);
        check("rst_data_out", DATA_OUT, 8'h00);
        check("rst_data_oe", DATA_OE, 1'b0);
        check("rst_cmd_drop", cmd_drop, 1'b0);
        check("rst_shift_ofs", shift_ofs, 6'd0);
        check("rst_disp_flags", {disp_on, cursor_on, blink_on}, 3'b000);
        check("rst_busy", busy, 1'b1);

        rst_n = 1'b1;
        wait_idle(k);
        check("powerup_busy_cycles", k, CLR);
        mon_chk("pwr_fill_00", 7'h00, 8'h20);
        mon_chk("pwr_fill_27", 7'h27, 8'h20);
        mon_chk("pwr_fill_40", 7'h40, 8'h20);
        mon_chk("pwr_fill_67", 7'h67, 8'h20);
        status("status_idle_ac0", 8'h00);

        bus_write(1'b0, 8'h06);
        wait_idle(k);
        check("cmd_busy_cycles", k, CMD - 1);
        bus_write(1'b1, 8'h41);
        status("status_during_busy", 8'h81);
        wait_idle(k);
        status("status_after_write", 8'h01);
        mon_chk("ddram_00_A", 7'h00, 8'h41);

        // Data read while busy returns 0x00 and leaves AC alone.
        bus_write(1'b1, 8'h42);
        bus_read("data_read_busy", 1'b1, 8'h00);
        wait_idle(k);
        status("ac_kept_busy_read", 8'h02);
        mon_chk("ddram_01_B", 7'h01, 8'h42);

        cmd(8'h80);
        bus_read("data_read_00", 1'b1, 8'h41);
        wait_idle(k);
        check("read_busy_cycles", k, DAT - 1);
        status("ac_after_read", 8'h01);

        cmd(8'hA7);
        dwrite(8'h5A);
        mon_chk("ddram_27", 7'h27, 8'h5A);
        status("ac_inc_27_40", 8'h40);
        cmd(8'h04);
        cmd(8'h80);
        dwrite(8'h61);
        mon_chk("ddram_00_a", 7'h00, 8'h61);
        status("ac_dec_00_67", 8'h67);
        cmd(8'hC0);
        dwrite(8'h62);
        mon_chk("ddram_40", 7'h40, 8'h62);
        status("ac_dec_40_27", 8'h27);
        cmd(8'hB0);
        status("ac_invalid_stored", 8'h30);
        dwrite(8'h63);
        status("ac_invalid_wrap", 8'h40);
        mon_chk("ddram_40_kept", 7'h40, 8'h62);
        cmd(8'h14);
        status("ac_shift_right", 8'h41);

        cmd(8'h7F);
        status("cg_ac_3f", 8'h3F);
        dwrite(8'h55);
        status("cg_dec", 8'h3E);
        cmd(8'h06);
        cmd(8'h7F);
        dwrite(8'h56);
        status("cg_wrap_6bit", 8'h00);
        cmd(8'h7F);
`ifdef LCD_16X2_RESP_CGRAM_EN
        bus_read("cg_read", 1'b1, 8'h56);
`else
        bus_read("cg_read", 1'b1, 8'h00);
`endif
        wait_idle(k);
        status("cg_read_step", 8'h00);
        mon_chk("ddram_00_after_cg", 7'h00, 8'h61);

        // Clear, then a data write ~100 cycles in lands while busy and must be discarded.
        bus_write(1'b0, 8'h01);
        repeat (96) @(negedge clk);
        drop_q.push_back(1'b1);
        bus_write(1'b1, 8'h77);
        wait_idle(k);
        mon_chk("clr_fill_00", 7'h00, 8'h20);
        mon_chk("clr_fill_27", 7'h27, 8'h20);
        mon_chk("clr_fill_40", 7'h40, 8'h20);
        mon_chk("clr_fill_67", 7'h67, 8'h20);
        status("ac_after_clear", 8'h00);
        dwrite(8'h41);
        status("id_set_by_clear", 8'h01);

        for (int i = 1; i <= 40; i++) begin
            cmd(8'h1C);
            check($sformatf("shift_right_%0d", i), shift_ofs, i % 40);
        end
        cmd(8'h18);
        check("shift_left_wrap", shift_ofs, 6'd39);
        bus_write(1'b0, 8'h02);
        wait_idle(k);
        check("home_busy_cycles", k, CLR - 1);
        check("home_shift", shift_ofs, 6'd0);
        status("home_ac", 8'h00);
        cmd(8'h0A);
        check("disp_ctrl_0a", {disp_on, cursor_on, blink_on}, 3'b010);
        cmd(8'h0F);
        check("disp_ctrl_0f", {disp_on, cursor_on, blink_on}, 3'b111);

        cmd(8'h80);
        dwrite(8'h11);
        cmd(8'hA7);
        dwrite(8'h22);
        cmd(8'hA7);
        bus_read("data_read_27", 1'b1, 8'h22);
        wait_idle(k);

        // Reset while the clear sweep is at address 30.
        bus_write(1'b0, 8'h01);
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data_out", DATA_OUT, 8'h00);
        check("mid_rst_data_oe", DATA_OE, 1'b0);
        check("mid_rst_cmd_drop", cmd_drop, 1'b0);
        check("mid_rst_disp_flags", {disp_on, cursor_on, blink_on}, 3'b000);
        check("mid_rst_shift", shift_ofs, 6'd0);
        check("mid_rst_busy", busy, 1'b1);
        mon_chk("sweep_done_00", 7'h00, 8'h20);
        mon_chk("sweep_not_27", 7'h27, 8'h22);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 20) begin
                peek(7'h27, v);
                check("sweep_restarted", v, 8'h22);
            end
        end while (busy && k < 4 * CLR);
        check("rst_clear_cycles", k, CLR);
        mon_chk("rst_fill_27", 7'h27, 8'h20);
        mon_chk("rst_fill_00", 7'h00, 8'h20);
        status("status_after_rst", 8'h00);

        repeat (5) @(negedge clk);
        check("reads_outstanding", rd_q.size(), 0);
        check("drops_outstanding", drop_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
